// File: rtl/down_count_monitor_pkg.sv
// down_count_monitor_pkg: shared state encoding, default parameters and helpers
package down_count_monitor_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      TRACK   = 2'd2,
      LOCKOUT = 2'd3
   } state_t;

   localparam int DEF_W             = 4;
   localparam int DEF_STABLE_CYCLES = 3;
   localparam int DEF_ERR_LIMIT     = 4;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/down_count_monitor_count_settle_filter.sv
// count_settle_filter: synchronises the raw count and accepts each value once it has settled
module count_settle_filter
   import down_count_monitor_pkg::*;
#(
   parameter int W             = DEF_W,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] cnt_in,
   output logic         accept_pulse,
   output logic [W-1:0] accept_val
);

   localparam logic [3:0] SC = 4'(STABLE_CYCLES);

   logic [W-1:0] s1;
   logic [W-1:0] s2;
   logic [W-1:0] cand;
   logic [3:0]   stab;
   logic [3:0]   stab_n;
   logic         changed;

   // a new synchronised value restarts the run, an unchanged one extends it up to SC
   always_comb begin
      changed = s2 != cand;
      stab_n  = changed ? 4'd1 : ((stab < SC) ? stab + 4'd1 : stab);
   end

   // two-flop synchroniser, candidate register, stability counter and one-shot accept
   always_ff @(posedge clk) begin
      if (rst) begin
         s1           <= '0;
         s2           <= '0;
         cand         <= '0;
         stab         <= '0;
         accept_pulse <= 1'b0;
      end else begin
         s1           <= cnt_in;
         s2           <= s1;
         cand         <= s2;
         stab         <= stab_n;
         accept_pulse <= (stab_n == SC) && (changed || stab != SC);
      end
   end

   assign accept_val = cand;

endmodule

// File: rtl/down_count_monitor.sv
// down_count_monitor: checks that settled counter values step down by one and flags faults
module down_count_monitor
   import down_count_monitor_pkg::*;
#(
   parameter int W             = DEF_W,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int ERR_LIMIT     = DEF_ERR_LIMIT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] cnt_in,
   input  logic         chk_en,
   output logic [W-1:0] cur_val,
   output logic         val_valid,
   output logic         wrap_pulse,
   output logic         step_err,
   output logic         fault,
   output logic [7:0]   wrap_cnt,
   output logic [7:0]   err_cnt
);

   state_t       state;
   state_t       state_n;
   logic         accept_pulse;
   logic [W-1:0] accept_val;
   logic [W-1:0] cur_n;
   logic         vv_n;
   logic         wp_n;
   logic         se_n;
   logic [7:0]   wc_n;
   logic [7:0]   ec_n;
   logic [3:0]   cerr;
   logic [3:0]   ce_n;

   count_settle_filter #(
      .W            (W),
      .STABLE_CYCLES(STABLE_CYCLES)
   ) u_filter (
      .clk         (clk),
      .rst         (rst),
      .cnt_in      (cnt_in),
      .accept_pulse(accept_pulse),
      .accept_val  (accept_val)
   );

   // next state and next outputs; a falling chk_en overrides any accept in the same cycle
   always_comb begin
      state_n = state;
      cur_n   = cur_val;
      vv_n    = val_valid;
      wp_n    = 1'b0;
      se_n    = 1'b0;
      wc_n    = wrap_cnt;
      ec_n    = err_cnt;
      ce_n    = cerr;
      if (!chk_en) begin
         state_n = IDLE;
         vv_n    = 1'b0;
         ce_n    = '0;
      end else begin
         unique case (state)
            IDLE: state_n = ACQUIRE;
            ACQUIRE: begin
               if (accept_pulse) begin
                  cur_n   = accept_val;
                  vv_n    = 1'b1;
                  state_n = TRACK;
               end
            end
            TRACK: begin
               if (accept_pulse) begin
                  cur_n = accept_val;
                  if (accept_val == cur_val - W'(1)) begin
                     ce_n = '0;
                     wp_n = cur_val == '0;
                     wc_n = (cur_val == '0) ? sat_inc8(wrap_cnt) : wrap_cnt;
                  end else begin
                     se_n    = 1'b1;
                     ec_n    = sat_inc8(err_cnt);
                     ce_n    = cerr + 4'd1;
                     state_n = (ce_n == 4'(ERR_LIMIT)) ? LOCKOUT : TRACK;
                  end
               end
            end
            LOCKOUT: state_n = LOCKOUT;
         endcase
      end
   end

   // state and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cur_val    <= '0;
         val_valid  <= 1'b0;
         wrap_pulse <= 1'b0;
         step_err   <= 1'b0;
         wrap_cnt   <= '0;
         err_cnt    <= '0;
         cerr       <= '0;
      end else begin
         state      <= state_n;
         cur_val    <= cur_n;
         val_valid  <= vv_n;
         wrap_pulse <= wp_n;
         step_err   <= se_n;
         wrap_cnt   <= wc_n;
         err_cnt    <= ec_n;
         cerr       <= ce_n;
      end
   end

   assign fault = state == LOCKOUT;

endmodule

// File: tb/tb_down_count_monitor.sv
// tb_down_count_monitor: directed and random stimulus checked against a sample-history model
module tb_down_count_monitor;

   localparam int SC = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             chk_en = 1'b0;
   logic [3:0]       cnt_in = 4'h0;
   logic [1:0][3:0]  cv;
   logic [1:0]       vv;
   logic [1:0]       wp;
   logic [1:0]       se;
   logic [1:0]       ft;
   logic [1:0][7:0]  wc;
   logic [1:0][7:0]  ec;

   int checks = 0;
   int errors = 0;
   int wp_seen = 0;
   int se_seen = 0;

   int lim[2] = '{4, 15};
   int m_mode[2];
   int m_cur[2];
   int m_vv[2];
   int m_wp[2];
   int m_se[2];
   int m_wc[2];
   int m_ec[2];
   int m_ce[2];
   int hist[$];
   int s1m;
   int s2m;
   int acc;
   int av;
   int n;

   always #5 clk = ~clk;

   down_count_monitor #(.W(4), .STABLE_CYCLES(SC), .ERR_LIMIT(4)) d4 (
      .clk(clk), .rst(rst), .cnt_in(cnt_in), .chk_en(chk_en),
      .cur_val(cv[0]), .val_valid(vv[0]), .wrap_pulse(wp[0]), .step_err(se[0]),
      .fault(ft[0]), .wrap_cnt(wc[0]), .err_cnt(ec[0])
   );

   down_count_monitor #(.W(4), .STABLE_CYCLES(SC), .ERR_LIMIT(15)) d15 (
      .clk(clk), .rst(rst), .cnt_in(cnt_in), .chk_en(chk_en),
      .cur_val(cv[1]), .val_valid(vv[1]), .wrap_pulse(wp[1]), .step_err(se[1]),
      .fault(ft[1]), .wrap_cnt(wc[1]), .err_cnt(ec[1])
   );

   // reference: a value is accepted when the last SC synchronised samples agree and the one before differs
   always @(posedge clk) begin
      if (rst) begin
         hist = '{16};
         s1m = 0;
         s2m = 0;
         for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_cur[i] = 0; m_vv[i] = 0; m_wp[i] = 0;
            m_se[i] = 0; m_wc[i] = 0; m_ec[i] = 0; m_ce[i] = 0;
         end
      end else begin
         acc = 0;
         av = 0;
         n = hist.size();
         if (n >= SC + 1) begin
            acc = 1;
            av = hist[n-1];
            for (int k = 2; k <= SC; k++) if (hist[n-k] != av) acc = 0;
            if (hist[n-SC-1] == av) acc = 0;
         end
         for (int i = 0; i < 2; i++) begin
            m_wp[i] = 0;
            m_se[i] = 0;
            if (!chk_en) begin
               m_mode[i] = 0; m_vv[i] = 0; m_ce[i] = 0;
            end else if (m_mode[i] == 0) begin
               m_mode[i] = 1;
            end else if (m_mode[i] == 1 && acc != 0) begin
               m_cur[i] = av; m_vv[i] = 1; m_mode[i] = 2;
            end else if (m_mode[i] == 2 && acc != 0) begin
               if (av == (m_cur[i] + 15) % 16) begin
                  m_ce[i] = 0;
                  if (m_cur[i] == 0) begin
                     m_wp[i] = 1;
                     m_wc[i] = (m_wc[i] < 255) ? m_wc[i] + 1 : 255;
                  end
               end else begin
                  m_se[i] = 1;
                  m_ec[i] = (m_ec[i] < 255) ? m_ec[i] + 1 : 255;
                  m_ce[i]++;
                  if (m_ce[i] == lim[i]) m_mode[i] = 3;
               end
               m_cur[i] = av;
            end
         end
         hist.push_back(s2m);
         s2m = s1m;
         s1m = int'(cnt_in);
         while (hist.size() > SC + 1) void'(hist.pop_front());
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cmp_all();
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("cur_val[%0d]", i), 32'(cv[i]), 32'(m_cur[i]));
         chk($sformatf("val_valid[%0d]", i), 32'(vv[i]), 32'(m_vv[i]));
         chk($sformatf("wrap_pulse[%0d]", i), 32'(wp[i]), 32'(m_wp[i]));
         chk($sformatf("step_err[%0d]", i), 32'(se[i]), 32'(m_se[i]));
         chk($sformatf("fault[%0d]", i), 32'(ft[i]), 32'(m_mode[i] == 3));
         chk($sformatf("wrap_cnt[%0d]", i), 32'(wc[i]), 32'(m_wc[i]));
         chk($sformatf("err_cnt[%0d]", i), 32'(ec[i]), 32'(m_ec[i]));
      end
   endtask

   task automatic cyc(input int cycles);
      repeat (cycles) begin
         @(negedge clk);
         cmp_all();
         if (wp[0]) wp_seen++;
         if (se[0]) se_seen++;
      end
   endtask

   task automatic hold(input logic [3:0] v, input int cycles);
      cnt_in = v;
      cyc(cycles);
   endtask

   task automatic rearm();
      chk_en = 1'b0;
      cyc(1);
      chk_en = 1'b1;
   endtask

   initial begin
      logic [3:0] v;
      int bad;
      int j;
      // reset held with input present and checking enabled
      rst = 1'b1;
      cnt_in = 4'hA;
      chk_en = 1'b1;
      cyc(3);
      chk("rst_cur_val", 32'(cv[0]), 0);
      chk("rst_fault", 32'(ft[0]), 0);
      chk("rst_err_cnt", 32'(ec[0]), 0);
      rst = 1'b0;
      cyc(5);
      chk("acq_not_yet", 32'(vv[0]), 0);
      cyc(1);
      chk("acq_cur_val", 32'(cv[0]), 32'hA);
      chk("acq_valid", 32'(vv[0]), 1);
      cyc(3);
      // clean descending run through the wrap
      rearm();
      wp_seen = 0;
      foreach (lim[i]) begin end
      hold(4'h3, 8); hold(4'h2, 8); hold(4'h1, 8);
      hold(4'h0, 8); hold(4'hF, 8); hold(4'hE, 8);
      chk("t2_wrap_pulses", 32'(wp_seen), 1);
      chk("t2_wrap_cnt", 32'(wc[0]), 1);
      chk("t2_err_cnt", 32'(ec[0]), 0);
      // short glitch is filtered
      rearm();
      hold(4'h8, 8); hold(4'h2, 2); hold(4'h7, 8);
      chk("t3_cur_val", 32'(cv[0]), 7);
      chk("t3_err_cnt", 32'(ec[0]), 0);
      // single error then a clean step
      rearm();
      hold(4'h9, 8); hold(4'h5, 8); hold(4'h4, 8);
      chk("t4_err_cnt", 32'(ec[0]), 1);
      chk("t4_cur_val", 32'(cv[0]), 4);
      chk("t4_fault", 32'(ft[0]), 0);
      // consecutive errors into lockout
      rst = 1'b1;
      cnt_in = 4'h9;
      cyc(1);
      rst = 1'b0;
      se_seen = 0;
      hold(4'h9, 8); hold(4'h2, 8); hold(4'h7, 8); hold(4'hC, 8); hold(4'h1, 8);
      chk("t5_err_pulses", 32'(se_seen), 4);
      chk("t5_fault", 32'(ft[0]), 1);
      chk("t5_err_cnt", 32'(ec[0]), 4);
      hold(4'h3, 8);
      chk("t5_lock_cur", 32'(cv[0]), 1);
      chk_en = 1'b0;
      cyc(1);
      chk("t5_fault_clr", 32'(ft[0]), 0);
      chk("t5_valid_clr", 32'(vv[0]), 0);
      chk("t5_err_hold", 32'(ec[0]), 4);
      chk_en = 1'b1;
      // saturate err_cnt on the ERR_LIMIT=15 instance
      bad = 0;
      v = cnt_in;
      while (bad < 260) begin
         rearm();
         v = v + 4'd1;
         hold(v, $urandom_range(4, 7));
         j = 0;
         while (j < 14 && bad < 260) begin
            v = v + 4'd1;
            hold(v, $urandom_range(4, 7));
            j++;
            bad++;
         end
      end
      chk("t6_err_sat", 32'(ec[1]), 255);
      chk("t6_no_fault", 32'(ft[1]), 0);
      hold(v + 4'd2, 2);
      rst = 1'b1;
      cyc(1);
      chk("t6_rst_err", 32'(ec[1]), 0);
      chk("t6_rst_cur", 32'(cv[1]), 0);
      chk("t6_rst_valid", 32'(vv[1]), 0);
      rst = 1'b0;
      // random mix of clean steps, errors, glitches and enable drops
      v = 4'h5;
      for (int k = 0; k < 200; k++) begin
         if ($urandom_range(0, 9) == 0) rearm();
         v = ($urandom_range(0, 2) != 0) ? v - 4'd1 : 4'($urandom_range(0, 15));
         hold(v, $urandom_range(1, 8));
      end
      cyc(10);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/down_count_monitor.md
Name: down_count_monitor

Overview:
- Downstream consumer of the 4-bit ripple down-counter output.
- Synchronises the count into the system clock domain and waits for each new value to settle, filtering out ripple transients.
- Checks that each settled value is exactly the previous value minus 1, modulo 2^W.
- Emits one-cycle wrap and error pulses, keeps saturating event counters, and enters a sticky fault state after repeated sequence errors.

Parameters:
- W, 4, width of the monitored count.
- STABLE_CYCLES, 3, consecutive identical synchronised samples required before a value is accepted (legal range 1..15).
- ERR_LIMIT, 4, consecutive step errors that force LOCKOUT (legal range 1..15).

Ports:
- clk  input  1  system clock; all flops on its rising edge.
- rst  input  1  synchronous, active-high reset.
- cnt_in  input  W  raw counter value; asynchronous to clk, may glitch during ripple.
- chk_en  input  1  enable checking; 0 forces IDLE.
- cur_val  output  W  last accepted value.
- val_valid  output  1  cur_val holds an accepted value.
- wrap_pulse  output  1  one-cycle pulse when an accepted step goes 0 -> 2^W-1.
- step_err  output  1  one-cycle pulse when an accepted value is not previous-1.
- fault  output  1  sticky; high while in LOCKOUT.
- wrap_cnt  output  8  saturating count of wraps.
- err_cnt  output  8  saturating count of step errors.

Behaviour:
- Reset (rst=1 at a clk edge): all of the following are cleared.
  - Outputs: cur_val=0, val_valid=0, wrap_pulse=0, step_err=0, fault=0, wrap_cnt=0, err_cnt=0.
  - Internal: sync flops=0, candidate=0, stability counter=0, consecutive-error counter=0, state=IDLE.
  - rst overrides chk_en and any in-flight acceptance.
- Synchroniser: two flops, cnt_in -> s1 -> s2. This runs in every state except reset.
- Settle filter:
  - If s2 != candidate: candidate <= s2 and stab <= 1.
  - Otherwise stab increments, saturating at STABLE_CYCLES.
  - An "accept" fires for one cycle when stab reaches STABLE_CYCLES. It fires once per settled value and does not repeat while the value holds.
- Latency: once cnt_in is steady, the pulses and cur_val update exactly STABLE_CYCLES+3 clk edges after the first edge that samples the new value. With defaults this is 6.
- FSM states: IDLE, ACQUIRE, TRACK, LOCKOUT.
  - IDLE:
    - chk_en=0 here means val_valid=0, no pulses, counters hold.
    - Goes to ACQUIRE when chk_en=1.
  - ACQUIRE:
    - On accept: cur_val <= value, val_valid <= 1, go to TRACK.
    - No check is performed on this first value.
  - TRACK, on each accept, with expected = (cur_val - 1) mod 2^W:
    - value == expected: clear the consecutive-error counter. If cur_val==0, pulse wrap_pulse and increment wrap_cnt.
    - value != expected: pulse step_err, increment err_cnt, increment the consecutive-error counter.
    - In both cases cur_val <= value; a mismatch resynchronises to the new value.
    - If the consecutive-error counter reaches ERR_LIMIT, go to LOCKOUT.
  - LOCKOUT:
    - fault=1; accepts are ignored; cur_val and the counters hold.
    - Leaves only via chk_en=0 (-> IDLE, fault cleared, val_valid cleared) or rst.
  - chk_en dropping in any state goes to IDLE on the next edge.
    - wrap_cnt and err_cnt hold; they are cleared only by rst.
    - The settle filter keeps running, so re-enabling acquires fresh.
- Both counters saturate at 255 and never wrap.
- Simultaneous accept and chk_en falling edge: the chk_en transition wins and that accept is discarded.
- wrap_pulse and step_err are never high in the same cycle.
- The ERR_LIMIT-th error pulses step_err and asserts fault on the same edge.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'd0, ACQUIRE=2'd1, TRACK=2'd2, LOCKOUT=2'd3.
  - Default constants for W, STABLE_CYCLES and ERR_LIMIT.
  - An 8-bit saturating-increment function.
- One natural sub-module: count_settle_filter.
  - Contains the two-flop synchroniser, candidate register and stability counter.
  - Outputs accept_pulse and accept_val.
- The top holds the FSM, checks and counters.

Test Plan:
1. rst=1 for 3 cycles with cnt_in=4'hA and chk_en=1 -> all outputs 0 and state IDLE throughout; after release, 4'hA is accepted with cur_val=4'hA and val_valid=1 at cycle 6+1, and no pulse.
2. chk_en=1, cnt_in steps 3,2,1,0,F,E, each held 8 cycles -> no step_err; exactly one wrap_pulse on the 0->F accept; wrap_cnt=1, err_cnt=0.
3. cnt_in=8, then glitch to 2 for 2 cycles, then 7 held -> the glitch is never accepted; 8->7 is accepted with no step_err.
4. Sequence 9,5,4 -> step_err pulses once on 9->5 and err_cnt=1; 5->4 is clean and the consecutive-error counter is cleared; fault=0.
5. Four consecutive bad steps 9,2,7,C,1 -> step_err pulses 4 times; fault=1 on the fourth; further values do not change cur_val; chk_en=0 for 1 cycle -> fault=0, state IDLE, err_cnt still 4.
6. Force err_cnt to 255 with 260 bad steps (ERR_LIMIT=15, chk_en toggled between bursts) -> err_cnt stays 255; rst mid-sequence clears everything on the next edge.
